// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle instruction sequencer. Each instruction is
// fetched, has its operands read, is executed and written back through a chain
// of request/acknowledge handshakes. After that the next pc is resolved as
// sequential, branch, jump or halt.
//
// Handshake contract, shared by the fetch, rd, alu and wb channels:
//   * A channel's *_req is registered. It rises in the first cycle of its wait
//     state and stays high for every cycle of that state.
//   * The sequencer takes a transfer on the rising edge where *_req and the
//     matching *_ack are both high. The req is low in the cycle after that,
//     unless the next state uses the same channel (WB0 -> WB1 keeps wb_req high
//     and flips wb_sel).
//   * An ack is ignored while its channel's req is low.
//   * While the sequencer waits, a counter tracks the cycles that have no ack.
//     If that counter would reach TIMEOUT, the sequencer stops in ERROR. An ack
//     on that same edge still wins over the timeout.
module exec_sequencer #(
  parameter int PC_W     = 8,
  parameter int WB_PORTS = 2,
  parameter int TIMEOUT  = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [PC_W-1:0] start_pc,
  output logic            fetch_req,
  output logic [PC_W-1:0] fetch_pc,
  input  logic            fetch_ack,
  input  logic [31:0]     fetch_ins,
  output logic            rd_req,
  input  logic            rd_ack,
  output logic            alu_req,
  output logic [2:0]      alu_op,
  input  logic            alu_ack,
  output logic            wb_req,
  output logic            wb_sel,
  input  logic            wb_ack,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic            error,
  output logic [15:0]     retired,
  output logic [3:0]      dbgState,
  output logic [31:0]     dbgIns
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_FETCH = 4'd1,
    S_READ  = 4'd2,
    S_EXEC  = 4'd3,
    S_WB0   = 4'd4,
    S_WB1   = 4'd5,
    S_NEXT  = 4'd6,
    S_HALT  = 4'd7,
    S_ERROR = 4'd8
  } state_t;

  state_t          state;
  state_t          stateNext;
  logic [31:0]     insReg;
  logic [7:0]      waitCnt;
  logic            ack;
  logic            waiting;
  logic            timeoutHit;
  logic            startOk;
  logic [PC_W-1:0] pcInc;
  logic [PC_W-1:0] pcNext;

  // Decoded fields of the captured instruction.
  logic [1:0] nxt;
  logic       brEn;
  logic [2:0] brOff;
  logic       jEn;
  logic [5:0] jTgt;

  assign nxt      = insReg[12:11];
  assign brEn     = insReg[10];
  assign brOff    = insReg[9:7];
  assign jEn      = insReg[6];
  assign jTgt     = insReg[5:0];
  assign alu_op   = insReg[31:29];
  assign fetch_pc = pc;
  assign dbgState = state;
  assign dbgIns   = insReg;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= stateNext;
  end

  // Next-state logic: select the ack of the current wait state and resolve the next pc.
  always_comb begin
    ack        = 1'b0;
    waiting    = 1'b0;
    stateNext  = state;
    timeoutHit = (waitCnt == 8'(TIMEOUT - 1));
    startOk    = start && (state == S_IDLE || state == S_HALT || state == S_ERROR);
    pcInc      = pc + PC_W'(1);
    pcNext     = pcInc;

    // Operands are zero-extended (or truncated) to PC_W and wrap naturally.
    case (nxt)
      2'b01:   pcNext = brEn ? pc + PC_W'(brOff) : pcInc;
      2'b10:   pcNext = jEn ? PC_W'(jTgt) : pcInc;
      2'b11:   pcNext = pc;
      default: pcNext = pcInc;
    endcase

    case (state)
      S_FETCH: begin waiting = 1'b1; ack = fetch_ack; end
      S_READ:  begin waiting = 1'b1; ack = rd_ack;    end
      S_EXEC:  begin waiting = 1'b1; ack = alu_ack;   end
      S_WB0,
      S_WB1:   begin waiting = 1'b1; ack = wb_ack;    end
      default: begin waiting = 1'b0; ack = 1'b0;      end
    endcase

    case (state)
      S_IDLE, S_HALT, S_ERROR: if (startOk) stateNext = S_FETCH;
      S_FETCH: stateNext = ack ? S_READ : (timeoutHit ? S_ERROR : S_FETCH);
      S_READ:  stateNext = ack ? S_EXEC : (timeoutHit ? S_ERROR : S_READ);
      S_EXEC:  stateNext = ack ? S_WB0  : (timeoutHit ? S_ERROR : S_EXEC);
      S_WB0: begin
        if (ack)             stateNext = (WB_PORTS == 2) ? S_WB1 : S_NEXT;
        else if (timeoutHit) stateNext = S_ERROR;
      end
      S_WB1:   stateNext = ack ? S_NEXT : (timeoutHit ? S_ERROR : S_WB1);
      S_NEXT:  stateNext = (nxt == 2'b11) ? S_HALT : S_FETCH;
      default: stateNext = S_IDLE;
    endcase
  end

  // Datapath: instruction capture, wait counter, pc and retired count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      insReg  <= '0;
      waitCnt <= '0;
      pc      <= '0;
      retired <= '0;
      error   <= 1'b0;
    end else begin
      if (state == S_FETCH && fetch_ack) insReg <= fetch_ins;

      // Any state change restarts the count, so each wait state starts at zero.
      if (stateNext != state)  waitCnt <= '0;
      else if (waiting && !ack) waitCnt <= waitCnt + 8'd1;

      if (startOk) begin
        pc      <= start_pc;
        retired <= '0;
      end else if (state == S_NEXT) begin
        pc <= pcNext;
        if (retired != 16'hFFFF) retired <= retired + 16'd1;
      end

      if (startOk)                  error <= 1'b0;
      else if (stateNext == S_ERROR) error <= 1'b1;
    end
  end

  // Registered handshake and status outputs, decoded from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_req <= 1'b0;
      rd_req    <= 1'b0;
      alu_req   <= 1'b0;
      wb_req    <= 1'b0;
      wb_sel    <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
    end else begin
      fetch_req <= (stateNext == S_FETCH);
      rd_req    <= (stateNext == S_READ);
      alu_req   <= (stateNext == S_EXEC);
      wb_req    <= (stateNext == S_WB0) || (stateNext == S_WB1);
      wb_sel    <= (stateNext == S_WB1);
      busy      <= (stateNext == S_FETCH) || (stateNext == S_READ) ||
                   (stateNext == S_EXEC)  || (stateNext == S_WB0)  ||
                   (stateNext == S_WB1)   || (stateNext == S_NEXT);
      halted    <= (stateNext == S_HALT);
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: a two-port instance with a short timeout that is
// driven through directed and random programs, plus a one-port instance whose
// acks are tied high.
module tb_exec_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT (WB_PORTS=2, TIMEOUT=4) ----------------
  logic        start = 1'b0;
  logic [7:0]  start_pc = '0;
  logic        fetch_req, fetch_ack = 1'b0;
  logic [7:0]  fetch_pc;
  logic [31:0] fetch_ins = '0;
  logic        rd_req, rd_ack = 1'b0;
  logic        alu_req, alu_ack = 1'b0;
  logic [2:0]  alu_op;
  logic        wb_req, wb_sel, wb_ack = 1'b0;
  logic [7:0]  pc;
  logic        busy, halted, error;
  logic [15:0] retired;
  logic [3:0]  dbgState;
  logic [31:0] dbgIns;

  exec_sequencer #(.PC_W(8), .WB_PORTS(2), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_ack(fetch_ack), .fetch_ins(fetch_ins),
    .rd_req(rd_req), .rd_ack(rd_ack),
    .alu_req(alu_req), .alu_op(alu_op), .alu_ack(alu_ack),
    .wb_req(wb_req), .wb_sel(wb_sel), .wb_ack(wb_ack),
    .pc(pc), .busy(busy), .halted(halted), .error(error), .retired(retired),
    .dbgState(dbgState), .dbgIns(dbgIns)
  );

  // ---------------- second DUT (WB_PORTS=1, acks tied high) ----------------
  logic        start1 = 1'b0;
  logic [31:0] ins1 = '0;
  logic        fetch_req1, rd_req1, alu_req1, wb_req1, wb_sel1;
  logic [7:0]  fetch_pc1, pc1;
  logic [2:0]  alu_op1;
  logic        busy1, halted1, error1;
  logic [15:0] retired1;
  logic [3:0]  dbgState1;
  logic [31:0] dbgIns1;

  exec_sequencer #(.PC_W(8), .WB_PORTS(1), .TIMEOUT(15)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .start_pc(8'h00),
    .fetch_req(fetch_req1), .fetch_pc(fetch_pc1), .fetch_ack(1'b1), .fetch_ins(ins1),
    .rd_req(rd_req1), .rd_ack(1'b1),
    .alu_req(alu_req1), .alu_op(alu_op1), .alu_ack(1'b1),
    .wb_req(wb_req1), .wb_sel(wb_sel1), .wb_ack(1'b1),
    .pc(pc1), .busy(busy1), .halted(halted1), .error(error1), .retired(retired1),
    .dbgState(dbgState1), .dbgIns(dbgIns1)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int expPc    = 0;
  int expRet   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Next pc computed from the instruction's fields with plain integer arithmetic.
  function automatic int modelNext(input int p, input logic [31:0] ins);
    int inc;
    int r;
    inc = (p + 1) % 256;
    r   = inc;
    case (ins[12:11])
      2'd1:    r = ins[10] ? (p + int'(ins[9:7])) % 256 : inc;
      2'd2:    r = ins[6] ? int'(ins[5:0]) : inc;
      2'd3:    r = p;
      default: r = inc;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] mkIns(input logic [1:0] nx, input logic be,
                                        input logic [2:0] off, input logic je,
                                        input logic [5:0] tgt);
    logic [2:0]  op;
    logic [15:0] fill;
    op   = 3'($urandom_range(0, 7));
    fill = 16'($urandom);
    return {op, fill, nx, be, off, je, tgt};
  endfunction

  // ---------------- driver tasks ----------------
  function automatic logic reqOf(input int w);
    case (w)
      0:       return fetch_req;
      1:       return rd_req;
      2:       return alu_req;
      default: return wb_req;
    endcase
  endfunction

  task automatic setAck(input int w, input logic v);
    case (w)
      0:       fetch_ack = v;
      1:       rd_ack    = v;
      2:       alu_ack   = v;
      default: wb_ack    = v;
    endcase
  endtask

  // Hold ack low for d cycles, then acknowledge. Called on a negedge inside the wait state.
  task automatic phase(input int w, input int d, input string tag);
    for (int i = 0; i < d; i++) begin
      chk({tag, "_req_hold"}, 32'(reqOf(w)), 32'd1);
      @(negedge clk);
    end
    chk({tag, "_req"}, 32'(reqOf(w)), 32'd1);
    setAck(w, 1'b1);
    @(negedge clk);
    setAck(w, 1'b0);
    if (w != 3) chk({tag, "_req_drop"}, 32'(reqOf(w)), 32'd0);
  endtask

  task automatic startAt(input logic [7:0] p);
    start_pc = p;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    expPc    = int'(p);
    expRet   = 0;
  endtask

  // Serve one complete instruction and check the pc and retired updates.
  task automatic runIns(input logic [31:0] ins, input int maxDly);
    logic halt;
    exp_q.push_back(32'(expPc));
    fetch_ins = ins;
    chk("fetch_pc", 32'(fetch_pc), exp_q.pop_front());
    chk("busy_fetch", 32'(busy), 32'd1);
    phase(0, $urandom_range(0, maxDly), "fetch");
    chk("alu_op_read", 32'(alu_op), 32'(ins[31:29]));
    phase(1, $urandom_range(0, maxDly), "read");
    phase(2, $urandom_range(0, maxDly), "exec");
    chk("wb_sel0", 32'(wb_sel), 32'd0);
    phase(3, $urandom_range(0, maxDly), "wb0");
    chk("wb_sel1", 32'(wb_sel), 32'd1);
    phase(4, $urandom_range(0, maxDly), "wb1");
    chk("next_reqs", 32'({fetch_req, rd_req, alu_req, wb_req}), 32'd0);
    chk("alu_op_next", 32'(alu_op), 32'(ins[31:29]));
    chk("retired_pre", 32'(retired), 32'(expRet));
    halt   = (ins[12:11] == 2'b11);
    expPc  = modelNext(expPc, ins);
    expRet = (expRet < 65535) ? expRet + 1 : expRet;
    @(negedge clk);
    chk("pc_next", 32'(pc), 32'(expPc));
    chk("retired", 32'(retired), 32'(expRet));
    chk("halted", 32'(halted), 32'(halt));
    chk("busy_after", 32'(busy), 32'(!halt));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int c0;
    int n;
    int wbCnt;
    logic selSeen;

    // Reset values while reset is held.
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_reqs", 32'({fetch_req, rd_req, alu_req, wb_req, wb_sel}), 32'd0);
    chk("rst_status", 32'({busy, halted, error}), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Three back-to-back instructions with immediate acks: 0,1,2 then halt after 18 cycles.
    startAt(8'h00);
    c0 = cyc;
    runIns(mkIns(2'b00, 1'b1, 3'd5, 1'b1, 6'h11), 0);
    runIns(mkIns(2'b00, 1'b1, 3'd2, 1'b1, 6'h22), 0);
    runIns(mkIns(2'b11, 1'b1, 3'd2, 1'b1, 6'h22), 0);
    chk("halt_latency", 32'(cyc - c0), 32'd18);
    chk("halt_pc", 32'(pc), 32'd2);
    chk("halt_retired", 32'(retired), 32'd3);

    // Branch that wraps past the top of the pc range, then a branch that is not taken.
    startAt(8'hFE);
    runIns(mkIns(2'b01, 1'b1, 3'd3, 1'b0, 6'h00), 1);
    chk("branch_wrap", 32'(pc), 32'h01);
    runIns(mkIns(2'b11, 1'b0, 3'd0, 1'b0, 6'h00), 1);
    startAt(8'hFE);
    runIns(mkIns(2'b01, 1'b0, 3'd3, 1'b0, 6'h00), 1);
    chk("branch_off", 32'(pc), 32'hFF);
    runIns(mkIns(2'b11, 1'b0, 3'd0, 1'b0, 6'h00), 1);

    // Jump.
    startAt(8'h10);
    runIns(mkIns(2'b10, 1'b0, 3'd0, 1'b1, 6'h2A), 2);
    chk("jump_fetch_pc", 32'(fetch_pc), 32'h2A);
    runIns(mkIns(2'b11, 1'b0, 3'd0, 1'b0, 6'h00), 2);

    // Random program with ack delays up to TIMEOUT-1 (the ack wins over the timeout on that edge).
    startAt(8'($urandom));
    for (int i = 0; i < 40; i++)
      runIns(mkIns(2'($urandom_range(0, 2)), 1'($urandom), 3'($urandom),
                   1'($urandom), 6'($urandom)), 3);
    runIns(mkIns(2'b11, 1'($urandom), 3'($urandom), 1'($urandom), 6'($urandom)), 3);

    // Timeout while waiting for rd_ack.
    startAt(8'h33);
    fetch_ins = mkIns(2'b00, 1'b0, 3'd0, 1'b0, 6'h00);
    phase(0, 0, "to_fetch");
    chk("to_rd_req", 32'(rd_req), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("to_waiting", 32'({rd_req, busy, error}), 32'b110);
    end
    @(negedge clk);
    chk("to_error", 32'(error), 32'd1);
    chk("to_reqs", 32'({fetch_req, rd_req, alu_req, wb_req}), 32'd0);
    chk("to_busy", 32'(busy), 32'd0);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    chk("to_sticky", 32'(error), 32'd1);
    startAt(8'h5A);
    chk("restart_error", 32'(error), 32'd0);
    chk("restart_fetch", 32'({fetch_req, fetch_pc}), {23'd0, 1'b1, 8'h5A});

    // Reset during EXEC with alu_ack high.
    fetch_ins = mkIns(2'b00, 1'b0, 3'd0, 1'b0, 6'h00) | 32'hE000_0000;
    phase(0, 0, "rs_fetch");
    phase(1, 0, "rs_read");
    chk("rs_alu_req", 32'(alu_req), 32'd1);
    alu_ack = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("rs_async_pc", 32'(pc), 32'd0);
    chk("rs_async_reqs", 32'({fetch_req, rd_req, alu_req, wb_req, wb_sel}), 32'd0);
    chk("rs_async_status", 32'({busy, halted, error}), 32'd0);
    chk("rs_async_alu_op", 32'(alu_op), 32'd0);
    @(negedge clk);
    alu_ack = 1'b0;

    // Release reset; the one-port instance starts on the very first edge.
    ins1   = mkIns(2'b10, 1'b0, 3'd0, 1'b1, 6'h2A);
    reset  = 1'b0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    c0 = cyc;
    chk("post_rst_start", 32'({fetch_req1, fetch_pc1}), {23'd0, 1'b1, 8'h00});
    chk("rs_retired", 32'(retired), 32'd0);
    chk("rs_idle", 32'({busy, wb_req, alu_req}), 32'd0);
    @(negedge clk);
    ins1 = mkIns(2'b11, 1'b0, 3'd0, 1'b0, 6'h00);
    n = 0;
    wbCnt = 0;
    selSeen = 1'b0;
    while (!halted1 && n < 60) begin
      if (wb_req1) wbCnt++;
      if (wb_sel1) selSeen = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("wb1_latency", 32'(cyc - c0), 32'd10);
    chk("wb1_jump_pc", 32'(pc1), 32'h2A);
    chk("wb1_retired", 32'(retired1), 32'd2);
    chk("wb1_wb_cycles", 32'(wbCnt), 32'd2);
    chk("wb1_sel_never", 32'(selSeen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Overall time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
